// File: rtl/pixel_scan_sequencer.sv
// Walks pixel_index over a WIDTH x HEIGHT frame and streams one RGB565 pixel per index.
// Optional SCAN_HIT_COUNT_EN adds a per-frame count of draw=1 pixels on hit_count.
module pixel_scan_sequencer #(
  parameter int WIDTH    = 96,
  parameter int HEIGHT   = 64,
  parameter int DRAW_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        draw,
  input  logic [15:0] fg_color,
  input  logic [15:0] bg_color,
  input  logic        out_ready,
  output logic [12:0] pixel_index,
  output logic [15:0] pixel_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [12:0] hit_count
);

  localparam logic [12:0] LAST_IDX  = 13'(WIDTH * HEIGHT - 1);
  localparam logic [1:0]  WAIT_INIT = 2'(DRAW_LAT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0] state;
  logic [1:0] wait_cnt;
  logic       capture;
  logic       accept;

  // Output handshake: a pixel transfers on a rising edge where out_valid and
  // out_ready are both 1; until then pixel_data, out_valid and out_last hold.
  assign capture = (state == S_WAIT) && (wait_cnt == 2'd0);
  assign accept  = (state == S_PRESENT) && out_valid && out_ready;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 2'd0;
      pixel_index <= 13'd0;
      pixel_data  <= 16'd0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pixel_index <= 13'd0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_INIT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            // draw and both colours are only looked at in this cycle
            pixel_data <= draw ? fg_color : bg_color;
            out_valid  <= 1'b1;
            out_last   <= (pixel_index == LAST_IDX);
            state      <= S_PRESENT;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_PRESENT: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= S_DONE;
            end else begin
              pixel_index <= pixel_index + 13'd1;
              state       <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_HIT_COUNT_EN
  logic [12:0] hit_acc;
  logic [12:0] hit_reg;

  // hit_reg is published only as the frame completes, so it reads stable between frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_acc <= 13'd0;
      hit_reg <= 13'd0;
    end else begin
      if ((state == S_IDLE) && start) begin
        hit_acc <= 13'd0;
      end else if (capture && draw) begin
        hit_acc <= hit_acc + 13'd1;
      end
      if (accept && out_last) begin
        hit_reg <= hit_acc;
      end
    end
  end

  assign hit_count = hit_reg;
`else
  assign hit_count = 13'd0;
`endif

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Directed bench: two sequencers (DRAW_LAT=1 and DRAW_LAT=2) share stimulus;
// a negedge scoreboard pops an expected queue per accepted pixel.
module tb_pixel_scan_sequencer;

  localparam int NPIX = 6144;

`ifdef SCAN_HIT_COUNT_EN
  localparam logic [12:0] HIT_ALL = 13'd6144;
  localparam logic [12:0] HIT_96  = 13'd96;
`else
  localparam logic [12:0] HIT_ALL = 13'd0;
  localparam logic [12:0] HIT_96  = 13'd0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        draw1 = 1'b0;
  logic        draw2;
  logic        out_ready = 1'b1;
  logic [15:0] fg = 16'h0000;
  logic [15:0] bg = 16'h0000;

  logic [12:0] idx1, idx2, hit1, hit2;
  logic [15:0] data1, data2;
  logic        valid1, valid2, last1, last2, busy1, busy2, done1, done2;

  pixel_scan_sequencer u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .draw(draw1),
    .fg_color(fg), .bg_color(bg), .out_ready(out_ready),
    .pixel_index(idx1), .pixel_data(data1), .out_valid(valid1),
    .out_last(last1), .busy(busy1), .done(done1), .hit_count(hit1)
  );

  pixel_scan_sequencer #(.DRAW_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .draw(draw2),
    .fg_color(fg), .bg_color(bg), .out_ready(out_ready),
    .pixel_index(idx2), .pixel_data(data2), .out_valid(valid2),
    .out_last(last2), .busy(busy2), .done(done2), .hit_count(hit2)
  );

  // shape model for dut2: hit on the first row, result two cycles after the index
  logic d_a = 1'b0;
  logic d_b = 1'b0;
  always @(posedge clk) begin
    d_a <= (idx2 < 13'd96);
    d_b <= d_a;
  end
  assign draw2 = d_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  logic [29:0] exp_q1[$];
  logic [29:0] exp_q2[$];
  bit sb_en = 1'b0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;

  always @(negedge clk) begin
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
    if (sb_en && rst_n) begin
      if (valid1 && out_ready) begin
        if (exp_q1.size() == 0) begin
          n_tests++; n_fail++;
          $error("FAIL sb1_extra: observed index %0d expected no pixel", idx1);
        end else begin
          check("sb1_pixel", 32'({last1, idx1, data1}), 32'(exp_q1.pop_front()));
        end
      end
      if (valid2 && out_ready) begin
        if (exp_q2.size() == 0) begin
          n_tests++; n_fail++;
          $error("FAIL sb2_extra: observed index %0d expected no pixel", idx2);
        end else begin
          check("sb2_pixel", 32'({last2, idx2, data2}), 32'(exp_q2.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic fill_q(input logic [15:0] f, input logic [15:0] b, input logic d1);
    exp_q1.delete();
    exp_q2.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_q1.push_back({(i == NPIX - 1), 13'(i), (d1 ? f : b)});
      exp_q2.push_back({(i == NPIX - 1), 13'(i), ((i < 96) ? f : b)});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_index(input logic [12:0] target, input int budget, input string tag);
    int c;
    c = 0;
    while (!(idx1 == target && valid1) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, 32'(idx1 == target && valid1), 32'd1);
  endtask

  int cycles, c1, c2, base1, base2;
  bit s1, s2;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_index", 32'(idx1), 32'd0);
    check("rst_data", 32'(data1), 32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_last", 32'(last1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_hit", 32'(hit1), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy1), 32'd0);

    // frame 1: draw1=1 everywhere, dut2 hits first row, out_ready held high
    fg = 16'hF800; bg = 16'h0000; draw1 = 1'b1;
    fill_q(fg, bg, 1'b1);
    sb_en = 1'b1;
    base1 = done_cnt1; base2 = done_cnt2;
    pulse_start();
    @(negedge clk);
    check("f1_busy", 32'(busy1), 32'd1);
    check("f1_index0", 32'(idx1), 32'd0);
    check("f1_valid_early", 32'(valid1), 32'd0);
    cycles = 0; c1 = 0; c2 = 0; s1 = 1'b0; s2 = 1'b0;
    while (!(s1 && s2) && cycles < 30000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (done1 && !s1) begin
        s1 = 1'b1; c1 = cycles;
        check("f1_hit1", 32'(hit1), 32'(HIT_ALL));
      end
      if (done2 && !s2) begin
        s2 = 1'b1; c2 = cycles;
        check("f1_hit2", 32'(hit2), 32'(HIT_96));
      end
    end
    check("f1_cycles1", 32'(c1), 32'd18432);
    check("f1_cycles2", 32'(c2), 32'd24576);
    repeat (3) @(negedge clk);
    check("f1_done_pulses1", 32'(done_cnt1 - base1), 32'd1);
    check("f1_done_pulses2", 32'(done_cnt2 - base2), 32'd1);
    check("f1_q1_drained", 32'(exp_q1.size()), 32'd0);
    check("f1_q2_drained", 32'(exp_q2.size()), 32'd0);
    check("f1_idle1", 32'(busy1), 32'd0);
    check("f1_hit1_held", 32'(hit1), 32'(HIT_ALL));
    check("f1_index_held", 32'(idx1), 32'd6143);

    // frame 2: stall at pixel 5, re-pulse start at pixel 100
    fg = 16'h07E0; bg = 16'h001F; draw1 = 1'b0;
    fill_q(fg, bg, 1'b0);
    base1 = done_cnt1; base2 = done_cnt2;
    pulse_start();
    wait_index(13'd5, 200, "f2_reach5");
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("f2_stall_data", 32'(data1), 32'h001F);
      check("f2_stall_valid", 32'(valid1), 32'd1);
      check("f2_stall_index", 32'(idx1), 32'd5);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_index(13'd100, 2000, "f2_reach100");
    pulse_start();
    @(negedge clk);
    check("f2_restart_ignored", 32'(idx1 >= 13'd100), 32'd1);
    cycles = 0;
    while ((done_cnt1 == base1 || done_cnt2 == base2) && cycles < 30000) begin
      @(negedge clk);
      cycles++;
    end
    repeat (3) @(negedge clk);
    check("f2_done_pulses1", 32'(done_cnt1 - base1), 32'd1);
    check("f2_done_pulses2", 32'(done_cnt2 - base2), 32'd1);
    check("f2_q1_drained", 32'(exp_q1.size()), 32'd0);
    check("f2_q2_drained", 32'(exp_q2.size()), 32'd0);
    check("f2_hit1", 32'(hit1), 32'd0);
    check("f2_hit2", 32'(hit2), 32'(HIT_96));

    // frame 3: reset mid-frame at pixel 3000, then immediate restart
    sb_en = 1'b0;
    fg = 16'hF800; bg = 16'h0000; draw1 = 1'b1;
    base1 = done_cnt1; base2 = done_cnt2;
    pulse_start();
    wait_index(13'd3000, 12000, "f3_reach3000");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("f3_rst_index", 32'(idx1), 32'd0);
    check("f3_rst_data", 32'(data1), 32'd0);
    check("f3_rst_valid", 32'(valid1), 32'd0);
    check("f3_rst_last", 32'(last1), 32'd0);
    check("f3_rst_busy", 32'(busy1), 32'd0);
    check("f3_rst_done", 32'(done1), 32'd0);
    check("f3_rst_hit1", 32'(hit1), 32'd0);
    check("f3_rst_hit2", 32'(hit2), 32'd0);
    check("f3_rst_busy2", 32'(busy2), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("f3_restart_busy", 32'(busy1), 32'd1);
    check("f3_restart_index", 32'(idx1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("f3_valid_wait", 32'(valid1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("f3_first_valid", 32'(valid1), 32'd1);
    check("f3_first_data", 32'(data1), 32'hF800);
    check("f3_first_index", 32'(idx1), 32'd0);
    check("f3_no_done1", 32'(done_cnt1 - base1), 32'd0);
    check("f3_no_done2", 32'(done_cnt2 - base2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
